cmd_sequencer: RTL and testbench

//  Scripted command sequencer that sits in front of CommMaster on the ground/bench side of the link.
//  It stores a short table of {cmd,data} entries and issues them to CommMaster in order, one per

---
 rtl/quad_cmd_pkg.sv | 34 +++
 rtl/cmd_sequencer_seq_tbl.sv | 62 ++++++
 rtl/cmd_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_cmd_sequencer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_cmd_pkg.sv
// ---------------------------------------------------------------------------
// quad_cmd_pkg
//   Shared definitions for the ground-side command sequencer that drives
//   CommMaster: command byte codes, the response byte meaning "accepted",
//   the stored table entry layout and the sequencer state encoding.
// ---------------------------------------------------------------------------
package quad_cmd_pkg;

  // Command bytes understood by the quadcopter side.
  localparam logic [7:0] CMD_CALIBRATE  = 8'h06;
  localparam logic [7:0] CMD_MOTORS_OFF = 8'h08;

  // Response byte meaning the command was accepted; anything else is a NAK.
  localparam logic [7:0] RESP_ACK = 8'hA5;

  // One scripted command as stored in the table (24 bits).
  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] data;
  } tbl_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FIN   = 3'd4
  } seq_state_t;

  function automatic logic is_ack(input logic [7:0] r);
    return (r == RESP_ACK);
  endfunction

endpackage

// File: rtl/cmd_sequencer_seq_tbl.sv
// ---------------------------------------------------------------------------
// seq_tbl
//   ENTRIES x 24-bit script table. Entries are appended at index cnt; the
//   read port is asynchronous. cnt is the only state that is reset -- the
//   stored contents are don't-care until written.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset (cnt only)
//   wr_en             append {wr_cmd,wr_data}; dropped when the table is full
//   wr_cmd, wr_data   entry to append
//   clr               empty the table; wins over a same-cycle wr_en
//   rd_idx            read index
//   rd_cmd, rd_data   entry at rd_idx
//   cnt               number of stored entries (0..ENTRIES)
// ---------------------------------------------------------------------------
module seq_tbl
  import quad_cmd_pkg::*;
#(
  parameter  int ENTRIES = 8,
  localparam int IDXW    = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [7:0]      wr_cmd,
  input  logic [15:0]     wr_data,
  input  logic            clr,
  input  logic [IDXW-1:0] rd_idx,
  output logic [7:0]      rd_cmd,
  output logic [15:0]     rd_data,
  output logic [IDXW:0]   cnt
);

  localparam logic [IDXW:0] CNT_FULL = (IDXW+1)'(ENTRIES);

  tbl_entry_t mem [ENTRIES];

  logic full;
  logic do_wr;

  assign full  = (cnt == CNT_FULL);
  assign do_wr = wr_en & ~clr & ~full;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[cnt[IDXW-1:0]] <= '{cmd: wr_cmd, data: wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (do_wr) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rd_cmd  = mem[rd_idx].cmd;
  assign rd_data = mem[rd_idx].data;

endmodule

// File: rtl/cmd_sequencer.sv
// ---------------------------------------------------------------------------
// cmd_sequencer
//   Replays a stored script of {cmd,data} entries to CommMaster, one
//   handshake per entry: pulse send_cmd, wait for resp_rdy, check the
//   response against ACK, knock down resp_rdy, advance. NAKs and response
//   timeouts are retried up to MAX_RETRY times per entry; the first entry
//   that still fails ends the run with err set and err_idx pointing at it.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_cmd/wr_data append an entry (ignored while busy or full)
//   clr_tbl             empty the table (ignored while busy)
//   strt                run the script from entry 0 (ignored while busy)
//   abort               return to IDLE next clock, no done pulse
//   cmd_sent            CommMaster frame-sent flag (informational only)
//   resp_rdy, resp      CommMaster response handshake
//   cmd, data           entry being issued, held until the next issue
//   send_cmd            1-clk start pulse to CommMaster
//   clr_resp_rdy        1-clk knock-down of CommMaster resp_rdy
//   busy                high while a script is running
//   done                1-clk pulse at the end of a run (pass or fail)
//   err, err_idx        sticky failure flag and failing entry index
//   cnt                 number of stored entries
// ---------------------------------------------------------------------------
module cmd_sequencer
  import quad_cmd_pkg::*;
#(
  parameter  int          ENTRIES   = 8,
  parameter  int unsigned TIMEOUT   = 100_000_000,
  parameter  int          MAX_RETRY = 2,
  localparam int          IDXW      = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [7:0]      wr_cmd,
  input  logic [15:0]     wr_data,
  input  logic            clr_tbl,
  input  logic            strt,
  input  logic            abort,
  input  logic            cmd_sent,
  input  logic            resp_rdy,
  input  logic [7:0]      resp,
  output logic [7:0]      cmd,
  output logic [15:0]     data,
  output logic            send_cmd,
  output logic            clr_resp_rdy,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [IDXW-1:0] err_idx,
  output logic [IDXW:0]   cnt
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

  seq_state_t         state, state_nxt;
  logic [IDXW-1:0]    idx, idx_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         resp_q;
  logic               miss;
  logic               fail;
  logic               err_clr;
  logic               last_entry;
  logic [7:0]         rd_cmd;
  logic [15:0]        rd_data;

  // cmd_sent only tells us the frame left the wire; the response handshake
  // is what paces the script, so it is deliberately not used.
  logic unused_cmd_sent;
  assign unused_cmd_sent = cmd_sent;

  // Table writes and clears are frozen while a script is running so the
  // entry count and contents cannot shift under the sequencer.
  seq_tbl #(
    .ENTRIES (ENTRIES)
  ) u_tbl (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en & ~busy),
    .wr_cmd  (wr_cmd),
    .wr_data (wr_data),
    .clr     (clr_tbl & ~busy),
    .rd_idx  (idx_nxt),
    .rd_cmd  (rd_cmd),
    .rd_data (rd_data),
    .cnt     (cnt)
  );

  assign last_entry = (({1'b0, idx} + 1'b1) == cnt);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;
    miss      = 1'b0;
    fail      = 1'b0;
    err_clr   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (strt) begin
          err_clr = 1'b1;
          if (cnt != '0) begin
            state_nxt = ST_ISSUE;
            idx_nxt   = '0;
            retry_nxt = '0;
          end else begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A response arriving on the last timer tick still counts.
        if (resp_rdy) begin
          state_nxt = ST_CHECK;
        end else if (timer == TIMER_LAST) begin
          miss = 1'b1;
        end
      end
      ST_CHECK: begin
        if (is_ack(resp_q)) begin
          if (last_entry) begin
            state_nxt = ST_FIN;
          end else begin
            state_nxt = ST_ISSUE;
            idx_nxt   = idx + 1'b1;
            retry_nxt = '0;
          end
        end else begin
          miss = 1'b1;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // NAK and timeout share one path: re-issue the same entry while
    // retries remain, otherwise end the run as a failure.
    if (miss) begin
      if (retry < RETRY_LIM) begin
        state_nxt = ST_ISSUE;
        retry_nxt = retry + 1'b1;
      end else begin
        state_nxt = ST_FIN;
        fail      = 1'b1;
      end
    end

    if (abort) begin
      state_nxt = ST_IDLE;
      idx_nxt   = idx;
      retry_nxt = retry;
      fail      = 1'b0;
      err_clr   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      retry   <= '0;
      timer   <= '0;
      resp_q  <= '0;
      cmd     <= '0;
      data    <= '0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      retry <= retry_nxt;

      // Counts only inside WAIT, where it never exceeds TIMEOUT-1 before
      // leaving, so it cannot wrap; every ISSUE restarts it from zero.
      if (state == ST_WAIT) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end

      if ((state == ST_WAIT) && resp_rdy) begin
        resp_q <= resp;
      end

      // Load the entry on the edge into ISSUE so cmd/data are already
      // valid while send_cmd is high and stay put until the next issue.
      if (state_nxt == ST_ISSUE) begin
        cmd  <= rd_cmd;
        data <= rd_data;
      end

      if (err_clr) begin
        err <= 1'b0;
      end else if (fail) begin
        err     <= 1'b1;
        err_idx <= idx;
      end
    end
  end

  assign send_cmd     = (state == ST_ISSUE);
  assign clr_resp_rdy = (state == ST_CHECK);
  assign done         = (state == ST_FIN);
  assign busy         = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_CHECK);

endmodule

// File: tb/tb_cmd_sequencer.sv
module tb_cmd_sequencer;

  localparam int ENT  = 8;
  localparam int TMO  = 100;
  localparam int MAXR = 2;
  localparam logic [7:0] ACKB = 8'hA5;

  typedef struct {
    int         d;   // response delay in WAIT cycles; 0 = never respond
    logic [7:0] r;
  } att_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_cmd = 8'h00;
  logic [15:0] wr_data = 16'h0000;
  logic        clr_tbl = 1'b0;
  logic        strt = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        send_cmd, clr_resp_rdy, busy, done, err;
  logic [2:0]  err_idx;
  logic [3:0]  cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Shared between the main sequence and the responder stub.
  att_t        plan[$];
  int          plan_gen = 0;
  logic [23:0] scr[$];
  logic [23:0] act_issue[$];
  int          act_icyc[$];
  int          act_clr = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_busy = 1'b0;

  int b_iss, b_clr, b_done, s_cyc;

  // Reference results
  logic [23:0] exp_issue[$];
  int          exp_clr, exp_len, exp_idx;
  logic        exp_err;

  cmd_sequencer #(
    .ENTRIES   (ENT),
    .TIMEOUT   (TMO),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_cmd       (wr_cmd),
    .wr_data      (wr_data),
    .clr_tbl      (clr_tbl),
    .strt         (strt),
    .abort        (abort),
    .cmd_sent     (cmd_sent),
    .resp_rdy     (resp_rdy),
    .resp         (resp),
    .cmd          (cmd),
    .data         (data),
    .send_cmd     (send_cmd),
    .clr_resp_rdy (clr_resp_rdy),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_idx      (err_idx),
    .cnt          (cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CommMaster stand-in: each send_cmd consumes the next planned response,
  // raises resp_rdy after d cycles, drops it on clr_resp_rdy; also logs.
  initial begin : stub
    att_t cur;
    int   wait_left;
    int   seen_gen;
    int   plan_ptr;
    logic sent_pend;
    cur.d = 0; cur.r = 8'h00;
    wait_left = 0; seen_gen = 0; plan_ptr = 0; sent_pend = 1'b0;
    resp_rdy = 1'b0; resp = 8'h00; cmd_sent = 1'b0;
    forever begin
      @(posedge clk); #1;
      cmd_sent = sent_pend;
      sent_pend = 1'b0;
      if (plan_gen != seen_gen) begin
        seen_gen = plan_gen;
        plan_ptr = 0;
      end
      if (!rst_n) begin
        wait_left = 0;
        resp_rdy = 1'b0;
      end else begin
        if (clr_resp_rdy) begin
          resp_rdy = 1'b0;
          act_clr++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          done_busy = busy;
        end
        if (send_cmd) begin
          act_issue.push_back({cmd, data});
          act_icyc.push_back(cyc);
          sent_pend = 1'b1;
          if (plan_ptr < plan.size()) cur = plan[plan_ptr];
          else begin cur.d = 0; cur.r = 8'h00; end
          plan_ptr++;
          wait_left = cur.d;
        end else if (wait_left > 0) begin
          wait_left--;
          if (wait_left == 0) begin
            resp_rdy = 1'b1;
            resp = cur.r;
          end
        end
      end
    end
  end

  // Reference: walk the script entry by entry, one planned response per
  // attempt, applying the ACK / retry / give-up rules directly.
  task automatic model_run();
    int idx, rt, m, n;
    att_t a;
    logic got;
    idx = 0; rt = 0; m = 0; n = scr.size();
    exp_issue.delete(); exp_clr = 0; exp_len = 0; exp_err = 1'b0; exp_idx = 0;
    while (n > 0) begin
      if (m < plan.size()) a = plan[m];
      else begin a.d = 0; a.r = 8'h00; end
      m++;
      exp_issue.push_back(scr[idx]);
      got = (a.d > 0) && (a.d <= TMO);
      if (got) begin exp_clr++; exp_len += a.d + 2; end
      else exp_len += TMO + 1;
      if (got && a.r == ACKB) begin
        if (idx == n - 1) break;
        idx++; rt = 0;
      end else if (rt < MAXR) begin
        rt++;
      end else begin
        exp_err = 1'b1; exp_idx = idx;
        break;
      end
    end
  endtask

  task automatic load_scr();
    @(posedge clk); #1; clr_tbl = 1'b1;
    @(posedge clk); #1; clr_tbl = 1'b0;
    foreach (scr[i]) begin
      wr_en = 1'b1; {wr_cmd, wr_data} = scr[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic start_script();
    plan_gen++;
    @(posedge clk); #1;
    b_iss = act_issue.size(); b_clr = act_clr; b_done = done_cnt;
    strt = 1'b1; s_cyc = cyc;
    @(posedge clk); #1; strt = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == b_done && k < budget) begin @(posedge clk); #1; k++; end
    repeat (2) begin @(posedge clk); #1; end
    tests++;
    if (done_cnt == b_done) begin
      fails++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
  endtask

  function automatic att_t att(input int d, input logic [7:0] r);
    att_t a;
    a.d = d; a.r = r;
    return a;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({send_cmd, clr_resp_rdy, busy, done, err} !== 5'b0) begin
      fails++; $display("FAIL reset_ctl: got %b want 00000", {send_cmd, clr_resp_rdy, busy, done, err});
    end
    tests++;
    if ({cmd, data, err_idx, cnt} !== '0) begin
      fails++; $display("FAIL reset_data: cmd=%h data=%h err_idx=%0d cnt=%0d want all 0", cmd, data, err_idx, cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy, done, cnt} !== '0) begin
      fails++; $display("FAIL reset_release: busy=%b done=%b cnt=%0d want 0", busy, done, cnt);
    end
  endtask

  task automatic test_two_entry();
    scr = '{24'h080420, 24'h06F0F0};
    plan = '{att(50, ACKB), att(50, ACKB)};
    load_scr();
    start_script();
    wait_done(1000);
    tests++;
    if (act_issue.size() - b_iss != 2 || act_issue[b_iss] !== 24'h080420 || act_issue[b_iss+1] !== 24'h06F0F0) begin
      fails++; $display("FAIL two_entry_issue: n=%0d first=%h want 2 issues 080420,06F0F0",
                        act_issue.size() - b_iss, act_issue[b_iss]);
    end
    tests++;
    if (act_clr - b_clr != 2 || err !== 1'b0) begin
      fails++; $display("FAIL two_entry_resp: clr=%0d err=%b want 2,0", act_clr - b_clr, err);
    end
    tests++;
    if (done_cyc != s_cyc + 1 + 2 * 52) begin
      fails++; $display("FAIL two_entry_time: done at +%0d want +%0d", done_cyc - s_cyc, 1 + 2 * 52);
    end
  endtask

  task automatic test_nak_retry();
    scr = '{24'h080420, 24'h06F0F0};
    plan = '{att(5, ACKB), att(5, 8'hEE), att(5, 8'hEE), att(5, ACKB)};
    load_scr();
    start_script();
    wait_done(1000);
    tests++;
    if (act_issue.size() - b_iss != 4 || act_issue[b_iss+3] !== 24'h06F0F0 || act_issue[b_iss+1] !== 24'h06F0F0) begin
      fails++; $display("FAIL nak_retry_issue: n=%0d want 4 (entry1 x3)", act_issue.size() - b_iss);
    end
    tests++;
    if (err !== 1'b0 || act_clr - b_clr != 4 || done_cyc != s_cyc + 1 + 4 * 7) begin
      fails++; $display("FAIL nak_retry_result: err=%b clr=%0d done+%0d want 0,4,+29",
                        err, act_clr - b_clr, done_cyc - s_cyc);
    end
  endtask

  task automatic test_timeout();
    scr = '{24'h080008, 24'h06F0F0};
    plan = '{att(0, 8'h00), att(0, 8'h00), att(0, 8'h00)};
    load_scr();
    start_script();
    wait_done(1000);
    tests++;
    if (act_issue.size() - b_iss != 3) begin
      fails++; $display("FAIL timeout_issues: got %0d want 3", act_issue.size() - b_iss);
    end else begin
      tests++;
      if (act_icyc[b_iss+1] - act_icyc[b_iss] != 101 || act_icyc[b_iss+2] - act_icyc[b_iss+1] != 101) begin
        fails++; $display("FAIL timeout_spacing: got %0d,%0d want 101,101",
                          act_icyc[b_iss+1] - act_icyc[b_iss], act_icyc[b_iss+2] - act_icyc[b_iss+1]);
      end
    end
    tests++;
    if (err !== 1'b1 || err_idx !== 3'd0 || act_clr != b_clr) begin
      fails++; $display("FAIL timeout_err: err=%b err_idx=%0d clr=%0d want 1,0,0", err, err_idx, act_clr - b_clr);
    end
  endtask

  task automatic test_edge_resp();
    scr = '{24'h060006};
    plan = '{att(TMO, ACKB)};
    load_scr();
    start_script();
    wait_done(1000);
    tests++;
    if (act_issue.size() - b_iss != 1 || err !== 1'b0 || act_clr - b_clr != 1 || done_cyc != s_cyc + 1 + TMO + 2) begin
      fails++; $display("FAIL edge_resp: issues=%0d err=%b clr=%0d done+%0d want 1,0,1,+%0d",
                        act_issue.size() - b_iss, err, act_clr - b_clr, done_cyc - s_cyc, TMO + 3);
    end
  endtask

  task automatic test_abort();
    int k;
    scr = '{24'h081111, 24'h062222};
    plan = '{att(3, ACKB), att(0, 8'h00)};
    load_scr();
    start_script();
    k = 0;
    while (act_issue.size() < b_iss + 2 && k < 300) begin @(posedge clk); #1; k++; end
    tests++;
    if (act_issue.size() < b_iss + 2) begin
      fails++; $display("FAIL abort_reach: entry 1 never issued (issues=%0d)", act_issue.size() - b_iss);
    end
    repeat (5) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    tests++;
    if ({busy, send_cmd, clr_resp_rdy} !== 3'b000) begin
      fails++; $display("FAIL abort_idle: busy/send/clr=%b want 000", {busy, send_cmd, clr_resp_rdy});
    end
    repeat (10) begin @(posedge clk); #1; end
    tests++;
    if (done_cnt != b_done || err !== 1'b0) begin
      fails++; $display("FAIL abort_nodone: done pulses=%0d err=%b want 0,0", done_cnt - b_done, err);
    end
    plan = '{att(4, ACKB), att(4, ACKB)};
    start_script();
    wait_done(500);
    tests++;
    if (act_issue.size() - b_iss != 2 || act_issue[b_iss] !== 24'h081111 || err !== 1'b0) begin
      fails++; $display("FAIL abort_restart: n=%0d first=%h err=%b want 2,081111,0",
                        act_issue.size() - b_iss, act_issue[b_iss], err);
    end
  endtask

  task automatic test_full_and_busy();
    scr.delete();
    for (int i = 0; i < 9; i++) scr.push_back(24'($urandom));
    load_scr();
    void'(scr.pop_back());
    tests++;
    if (cnt !== 4'd8) begin
      fails++; $display("FAIL full_cnt: got %0d want 8", cnt);
    end
    plan.delete();
    for (int i = 0; i < 8; i++) plan.push_back(att($urandom_range(1, 10), ACKB));
    model_run();
    start_script();
    repeat (3) begin @(posedge clk); #1; end
    wr_en = 1'b1; strt = 1'b1; {wr_cmd, wr_data} = 24'hFFFFFF; clr_tbl = 1'b1;
    @(posedge clk); #1; wr_en = 1'b0; strt = 1'b0; clr_tbl = 1'b0;
    wait_done(2000);
    repeat (20) begin @(posedge clk); #1; end
    tests++;
    if (cnt !== 4'd8 || done_cnt - b_done != 1 || act_issue.size() - b_iss != exp_issue.size()) begin
      fails++; $display("FAIL busy_ignore: cnt=%0d dones=%0d issues=%0d want 8,1,%0d",
                        cnt, done_cnt - b_done, act_issue.size() - b_iss, exp_issue.size());
    end else begin
      for (int i = 0; i < exp_issue.size(); i++) begin
        tests++;
        if (act_issue[b_iss+i] !== exp_issue[i]) begin
          fails++; $display("FAIL full_issue[%0d]: got %h want %h", i, act_issue[b_iss+i], exp_issue[i]);
        end
      end
    end
    @(posedge clk); #1; clr_tbl = 1'b1; wr_en = 1'b1;
    @(posedge clk); #1; clr_tbl = 1'b0; wr_en = 1'b0;
    tests++;
    if (cnt !== 4'd0) begin
      fails++; $display("FAIL clr_wins: cnt=%0d want 0", cnt);
    end
    start_script();
    wait_done(50);
    tests++;
    if (done_cyc != s_cyc + 1 || act_issue.size() != b_iss || err !== 1'b0) begin
      fails++; $display("FAIL empty_run: done+%0d issues=%0d err=%b want +1,0,0",
                        done_cyc - s_cyc, act_issue.size() - b_iss, err);
    end
  endtask

  task automatic test_async_reset();
    int k;
    scr = '{24'h08ABCD, 24'h061234};
    plan = '{att(0, 8'h00)};
    load_scr();
    start_script();
    k = 0;
    while (act_issue.size() == b_iss && k < 50) begin @(posedge clk); #1; k++; end
    repeat (5) begin @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({send_cmd, clr_resp_rdy, busy, done, err, err_idx, cmd, data, cnt} !== '0) begin
      fails++; $display("FAIL async_reset: busy=%b cmd=%h data=%h cnt=%0d want all 0", busy, cmd, data, cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_random();
    int n, p;
    logic [7:0] r;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, ENT);
      scr.delete();
      for (int i = 0; i < n; i++) scr.push_back(24'($urandom));
      plan.delete();
      for (int i = 0; i < n * (MAXR + 1); i++) begin
        p = $urandom_range(0, 99);
        r = 8'($urandom_range(0, 255));
        if (r == ACKB) r = 8'hEE;
        if (p < 65)      plan.push_back(att($urandom_range(1, 15), ACKB));
        else if (p < 82) plan.push_back(att($urandom_range(1, 15), r));
        else if (p < 93) plan.push_back(att(0, 8'h00));
        else             plan.push_back(att(TMO, ACKB));
      end
      model_run();
      load_scr();
      start_script();
      wait_done(5000);
      tests++;
      if (act_issue.size() - b_iss != exp_issue.size()) begin
        fails++; $display("FAIL rand%0d_count: issues=%0d want %0d", it, act_issue.size() - b_iss, exp_issue.size());
      end else begin
        for (int i = 0; i < exp_issue.size(); i++) begin
          tests++;
          if (act_issue[b_iss+i] !== exp_issue[i]) begin
            fails++; $display("FAIL rand%0d_issue[%0d]: got %h want %h", it, i, act_issue[b_iss+i], exp_issue[i]);
          end
        end
      end
      tests++;
      if (err !== exp_err || (exp_err && err_idx !== 3'(exp_idx))) begin
        fails++; $display("FAIL rand%0d_err: err=%b idx=%0d want %b,%0d", it, err, err_idx, exp_err, exp_idx);
      end
      tests++;
      if (act_clr - b_clr != exp_clr || done_cyc != s_cyc + 1 + exp_len || done_busy !== 1'b0) begin
        fails++; $display("FAIL rand%0d_timing: clr=%0d done+%0d busy@done=%b want %0d,+%0d,0",
                          it, act_clr - b_clr, done_cyc - s_cyc, done_busy, exp_clr, 1 + exp_len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_entry();
    test_nak_retry();
    test_timeout();
    test_edge_resp();
    test_abort();
    test_full_and_busy();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
